// File: rtl/lock_sequencer.sv
// Code-entry controller for the digital lock.
// Turns debounced button levels into digit presses, collects a CODE_LEN-digit
// entry, checks it against the stored secret, and drives the unlock, fail and
// lockout indications. The secret can be reprogrammed while unlocked.
module lock_sequencer #(
    parameter int                      CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0]   DEFAULT_CODE   = 8'b00_01_10_11,
    parameter int                      MAX_FAIL       = 3,
    parameter int                      UNLOCK_CYCLES  = 512,
    parameter int                      LOCKOUT_CYCLES = 1024,
    parameter int                      TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       prog_req,
    input  logic       relock,
    output logic       unlocked,
    output logic       fail_pulse,
    output logic       locked_out,
    output logic       prog_done,
    output logic [3:0] digit_count,
    output logic [2:0] state
);
    localparam int CW   = 2 * CODE_LEN;
    localparam int MAXA = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int MAXC = (MAXA > TIMEOUT_CYCLES) ? MAXA : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;
    localparam int FW   = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_PROGRAM  = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_t;

    state_t          st;
    logic [3:0]      btn_q;
    logic [3:0]      press_vec;
    logic            pressed;
    logic            multi;
    logic [1:0]      digit;
    logic            last_digit;
    logic            tmo;
    logic [CW-1:0]   entry_reg;
    logic [CW-1:0]   shadow_reg;
    logic [CW-1:0]   secret;
    logic            bad;
    logic [FW-1:0]   fail_cnt;
    logic [TW-1:0]   timer;

    assign state = st;

    // Rising-edge press decode; digit is only meaningful for a single-bit press
    always_comb begin
        press_vec  = btn & ~btn_q;
        pressed    = |press_vec;
        multi      = pressed && !$onehot(press_vec);
        digit      = 2'd0;
        for (int i = 0; i < 4; i++)
            if (press_vec[i]) digit = 2'(i);
        last_digit = (digit_count == 4'(CODE_LEN - 1));
        tmo        = (timer >= TW'(TIMEOUT_CYCLES - 1));
    end

    // Main sequencer: state, shared timer, entry/secret registers, registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= ST_ENTRY;
            btn_q       <= 4'b1111;
            entry_reg   <= '0;
            shadow_reg  <= '0;
            secret      <= DEFAULT_CODE;
            bad         <= 1'b0;
            fail_cnt    <= '0;
            timer       <= '0;
            unlocked    <= 1'b0;
            fail_pulse  <= 1'b0;
            locked_out  <= 1'b0;
            prog_done   <= 1'b0;
            digit_count <= 4'd0;
        end else begin
            btn_q      <= btn;
            fail_pulse <= 1'b0;
            prog_done  <= 1'b0;
            if (timer != '1) timer <= timer + 1'b1;

            case (st)
                ST_ENTRY: begin
                    if (pressed) begin
                        timer       <= '0;
                        entry_reg   <= {entry_reg[CW-3:0], digit};
                        digit_count <= digit_count + 4'd1;
                        if (multi) bad <= 1'b1;
                        if (last_digit) st <= ST_CHECK;
                    end else if (digit_count != 4'd0 && tmo) begin
                        digit_count <= 4'd0;
                        bad         <= 1'b0;
                    end
                end

                ST_CHECK: begin
                    timer       <= '0;
                    digit_count <= 4'd0;
                    bad         <= 1'b0;
                    if (!bad && entry_reg == secret) begin
                        st       <= ST_UNLOCKED;
                        unlocked <= 1'b1;
                        fail_cnt <= '0;
                    end else begin
                        fail_pulse <= 1'b1;
                        if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                            st         <= ST_LOCKOUT;
                            locked_out <= 1'b1;
                            fail_cnt   <= '0;
                        end else begin
                            st       <= ST_ENTRY;
                            fail_cnt <= fail_cnt + 1'b1;
                        end
                    end
                end

                ST_UNLOCKED: begin
                    if (relock || timer >= TW'(UNLOCK_CYCLES - 1)) begin
                        st       <= ST_ENTRY;
                        unlocked <= 1'b0;
                        timer    <= '0;
                    end else if (prog_req) begin
                        st          <= ST_PROGRAM;
                        timer       <= '0;
                        digit_count <= 4'd0;
                    end
                end

                ST_PROGRAM: begin
                    // prog_req is not watched here: once started, programming runs to commit or abort
                    if (pressed) begin
                        timer <= '0;
                        if (multi) begin
                            st          <= ST_ENTRY;
                            unlocked    <= 1'b0;
                            digit_count <= 4'd0;
                        end else begin
                            shadow_reg <= {shadow_reg[CW-3:0], digit};
                            if (last_digit) begin
                                secret      <= {shadow_reg[CW-3:0], digit};
                                prog_done   <= 1'b1;
                                st          <= ST_ENTRY;
                                unlocked    <= 1'b0;
                                digit_count <= 4'd0;
                            end else begin
                                digit_count <= digit_count + 4'd1;
                            end
                        end
                    end else if (tmo) begin
                        st          <= ST_ENTRY;
                        unlocked    <= 1'b0;
                        timer       <= '0;
                        digit_count <= 4'd0;
                    end
                end

                ST_LOCKOUT: begin
                    if (timer >= TW'(LOCKOUT_CYCLES - 1)) begin
                        st         <= ST_ENTRY;
                        locked_out <= 1'b0;
                        timer      <= '0;
                        fail_cnt   <= '0;
                    end
                end

                default: begin
                    st    <= ST_ENTRY;
                    timer <= '0;
                end
            endcase
        end
    end
endmodule
